// File: rtl/instr_encoder_if.sv
// Request and instruction-stream signals shared by the encoder and its
// driver. The slave view belongs to the encoder; the master view is the
// side that issues requests and consumes encoded words.
interface instr_encoder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  kind_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic [15:0] imm_i;
  logic [25:0] target_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] addr_o;
  logic [2:0]  level_o;
  logic        err_o;

  modport slave (
    input  req_valid_i, kind_i, rs_i, rt_i, rd_i, imm_i, target_i, instr_ready_i,
    output req_ready_o, instr_o, instr_valid_o, addr_o, level_o, err_o
  );

  modport master (
    output req_valid_i, kind_i, rs_i, rt_i, rd_i, imm_i, target_i, instr_ready_i,
    input  req_ready_o, instr_o, instr_valid_o, addr_o, level_o, err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: builds a 32-bit MIPS-style word from the request
// fields and queues it in a 4-entry FIFO. The output side presents the oldest
// word together with a running byte address that advances on each pop.
// Illegal kinds complete the handshake but are dropped and latch err_o.
module instr_encoder (
  input  logic            clk_i,
  input  logic            rst_i,
  instr_encoder_if.slave  bus
);

  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_AND  = 4'd2;
  localparam logic [3:0] K_OR   = 4'd3;
  localparam logic [3:0] K_MULT = 4'd4;
  localparam logic [3:0] K_ADDI = 4'd5;
  localparam logic [3:0] K_LW   = 4'd6;
  localparam logic [3:0] K_SW   = 4'd7;
  localparam logic [3:0] K_BEQ  = 4'd8;
  localparam logic [3:0] K_J    = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_MULT = 6'b011000;

  localparam logic [2:0] DEPTH = 3'd4;

  logic [31:0] enc_word;
  logic        enc_legal;

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  level;
  logic [31:0] addr;
  logic        err;

  logic        req_ready;
  logic        accept;
  logic        push;
  logic        pop;
  logic        not_empty;

  // Combinational encode of the presented request fields.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (bus.kind_i)
      K_ADD:   enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, FN_ADD};
      K_SUB:   enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, FN_SUB};
      K_AND:   enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, FN_AND};
      K_OR:    enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, FN_OR};
      // mult writes HI/LO, so the destination field is always zero.
      K_MULT:  enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, 5'd0, 5'd0, FN_MULT};
      K_ADDI:  enc_word = {OP_ADDI, bus.rs_i, bus.rt_i, bus.imm_i};
      K_LW:    enc_word = {OP_LW, bus.rs_i, bus.rt_i, bus.imm_i};
      K_SW:    enc_word = {OP_SW, bus.rs_i, bus.rt_i, bus.imm_i};
      K_BEQ:   enc_word = {OP_BEQ, bus.rs_i, bus.rt_i, bus.imm_i};
      K_J:     enc_word = {OP_J, bus.target_i};
      default: enc_legal = 1'b0;
    endcase
  end

  // Handshake qualifiers; readiness looks only at occupancy, never at the sink.
  always_comb begin
    not_empty = (level != 3'd0);
    req_ready = (level < DEPTH);
    accept    = bus.req_valid_i & req_ready;
    push      = accept & enc_legal;
    pop       = not_empty & bus.instr_ready_i;
  end

  // FIFO storage; contents are don't-care until written, so no reset here.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Pointers, occupancy, output address and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      level  <= 3'd0;
      addr   <= 32'd0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        addr   <= addr + 32'd4;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
      if (accept && !enc_legal) begin
        err <= 1'b1;
      end
    end
  end

  // Output drive; the word reads as zero whenever the queue is empty.
  always_comb begin
    bus.req_ready_o   = req_ready;
    bus.instr_valid_o = not_empty;
    bus.instr_o       = not_empty ? mem[rd_ptr] : 32'd0;
    bus.addr_o        = addr;
    bus.level_o       = level;
    bus.err_o         = err;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding vectors from a table plus hand-written
// sequences for back-pressure, illegal kinds, simultaneous push/pop and reset.
// A negedge monitor keeps a queue of expected words and checks every cycle.
module tb_instr_encoder;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] exp_q [$];
  logic [31:0] cur_exp;
  logic [31:0] m_addr;
  logic        m_err;
  bit          mon_en;
  bit          prev_hold;
  logic [31:0] prev_instr;
  bit          m_acc;
  bit          m_pop;

  vec_t tbl [12];

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle reference: occupancy, flags, head word and address.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 32'(bus.level_o), 32'(exp_q.size()));
      chk("req_ready", 32'(bus.req_ready_o), 32'(exp_q.size() < 4));
      chk("instr_valid", 32'(bus.instr_valid_o), 32'(exp_q.size() > 0));
      chk("err", 32'(bus.err_o), 32'(m_err));
      chk("addr", bus.addr_o, m_addr);
      if (prev_hold) begin
        chk("hold_instr", bus.instr_o, prev_instr);
      end
      if (exp_q.size() > 0) begin
        chk("head_word", bus.instr_o, exp_q[0]);
      end
      if (rst) begin
        exp_q.delete();
        m_addr    = 32'd0;
        m_err     = 1'b0;
        prev_hold = 1'b0;
      end else begin
        m_acc      = bus.req_valid_i && (exp_q.size() < 4);
        m_pop      = (exp_q.size() > 0) && bus.instr_ready_i;
        prev_hold  = (exp_q.size() > 0) && !bus.instr_ready_i;
        prev_instr = bus.instr_o;
        if (m_pop) begin
          void'(exp_q.pop_front());
          m_addr = m_addr + 32'd4;
        end
        if (m_acc) begin
          if (bus.kind_i <= 4'd9) exp_q.push_back(cur_exp);
          else m_err = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    bus.kind_i      = v.kind;
    bus.rs_i        = v.rs;
    bus.rt_i        = v.rt;
    bus.rd_i        = v.rd;
    bus.imm_i       = v.imm;
    bus.target_i    = v.tgt;
    cur_exp         = v.exp;
    bus.req_valid_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.req_ready_o;
      cyc();
    end
    bus.req_valid_i = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted at %0t", $time);
    end
  endtask

  function automatic vec_t addi_vec(input logic [15:0] imm);
    vec_t v;
    v.kind = 4'd5; v.rs = 5'd0; v.rt = 5'd0; v.rd = 5'd0;
    v.imm  = imm;  v.tgt = 26'd0;
    v.exp  = 32'h2000_0000 | {16'd0, imm};
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    m_addr = 32'd0;
    m_err  = 1'b0;
    mon_en = 1'b0;
    prev_hold = 1'b0;
    cur_exp = 32'd0;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.kind_i = 4'd0; bus.rs_i = 5'd0; bus.rt_i = 5'd0; bus.rd_i = 5'd0;
    bus.imm_i = 16'd0; bus.target_i = 26'd0;
    bus.instr_ready_i = 1'b0;

    tbl[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h0022_1820};
    tbl[1]  = '{4'd1, 5'd3,  5'd4,  5'd5,  16'h0000, 26'h0000000, 32'h0064_2822};
    tbl[2]  = '{4'd2, 5'd31, 5'd0,  5'd31, 16'h0000, 26'h0000000, 32'h03E0_F824};
    tbl[3]  = '{4'd3, 5'd0,  5'd31, 5'd1,  16'h0000, 26'h0000000, 32'h001F_0825};
    tbl[4]  = '{4'd4, 5'd1,  5'd2,  5'd7,  16'h0000, 26'h0000000, 32'h0022_0018};
    tbl[5]  = '{4'd5, 5'd2,  5'd3,  5'd9,  16'h1234, 26'h0000000, 32'h2043_1234};
    tbl[6]  = '{4'd6, 5'd4,  5'd5,  5'd0,  16'h0010, 26'h0000000, 32'h8C85_0010};
    tbl[7]  = '{4'd7, 5'd6,  5'd7,  5'd0,  16'h8000, 26'h0000000, 32'hACC7_8000};
    tbl[8]  = '{4'd8, 5'd1,  5'd1,  5'd0,  16'hFFFF, 26'h0000000, 32'h1021_FFFF};
    tbl[9]  = '{4'd9, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000040, 32'h0800_0040};
    tbl[10] = '{4'd9, 5'd5,  5'd6,  5'd7,  16'hABCD, 26'h3FFFFFF, 32'h0BFF_FFFF};
    tbl[11] = '{4'd4, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0000000, 32'h03FF_0018};

    // Reset state
    repeat (2) cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_level", 32'(bus.level_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    cyc();

    // Encoding table, sink always ready: one-cycle latency, addr steps by 4
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid_o), 32'd1);
      chk($sformatf("vec%0d_word", i), bus.instr_o, tbl[i].exp);
      chk($sformatf("vec%0d_addr", i), bus.addr_o, 32'(i * 4));
      cyc();
      chk($sformatf("vec%0d_addr_after", i), bus.addr_o, 32'((i + 1) * 4));
    end

    // Five back-to-back requests into a stalled sink
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = addi_vec(16'h0010 + 16'(i));
      bus.kind_i = v.kind; bus.rs_i = v.rs; bus.rt_i = v.rt; bus.rd_i = v.rd;
      bus.imm_i = v.imm; bus.target_i = v.tgt;
      cur_exp = v.exp;
      bus.req_valid_i = 1'b1;
      if (i == 4) begin
        @(negedge clk);
        chk("full_ready", 32'(bus.req_ready_o), 32'd0);
        chk("full_level", 32'(bus.level_o), 32'd4);
      end
      cyc();
    end
    bus.req_valid_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d", i), bus.instr_o, 32'h2000_0010 + 32'(i));
      cyc();
    end
    @(negedge clk);
    chk("drained_valid", 32'(bus.instr_valid_o), 32'd0);
    cyc();

    // Illegal kind: accepted, dropped, sticky error
    v = '{4'hA, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 32'h0};
    send(v);
    @(negedge clk);
    chk("illegal_level", 32'(bus.level_o), 32'd0);
    chk("illegal_err", 32'(bus.err_o), 32'd1);
    cyc();
    send(tbl[0]);
    send(tbl[6]);
    @(negedge clk);
    chk("err_sticky", 32'(bus.err_o), 32'd1);
    cyc();

    // Simultaneous push and pop at level 2
    bus.instr_ready_i = 1'b0;
    send(addi_vec(16'h0001));
    send(addi_vec(16'h0002));
    @(negedge clk);
    chk("pp_level_before", 32'(bus.level_o), 32'd2);
    chk("pp_head_before", bus.instr_o, 32'h2000_0001);
    cyc();
    bus.instr_ready_i = 1'b1;
    send(addi_vec(16'h0003));
    bus.instr_ready_i = 1'b0;
    @(negedge clk);
    chk("pp_level_after", 32'(bus.level_o), 32'd2);
    chk("pp_head_after", bus.instr_o, 32'h2000_0002);
    cyc();
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("pp_order%0d", i), bus.instr_o, 32'h2000_0002 + 32'(i));
      cyc();
    end

    // Reset mid-operation with a request presented in the reset cycle
    do_reset();
    for (int i = 0; i < 3; i++) send(addi_vec(16'h0100 + 16'(i)));
    repeat (2) cyc();
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(addi_vec(16'h0200 + 16'(i)));
    send('{4'hF, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0});
    @(negedge clk);
    chk("pre_rst_level", 32'(bus.level_o), 32'd3);
    chk("pre_rst_addr", bus.addr_o, 32'h0000_000C);
    chk("pre_rst_err", 32'(bus.err_o), 32'd1);
    cyc();
    v = addi_vec(16'h0300);
    bus.kind_i = v.kind; bus.imm_i = v.imm;
    cur_exp = v.exp;
    bus.req_valid_i = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_level", 32'(bus.level_o), 32'd0);
    chk("post_rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("post_rst_addr", bus.addr_o, 32'd0);
    chk("post_rst_err", 32'(bus.err_o), 32'd0);
    chk("post_rst_instr", bus.instr_o, 32'd0);
    cyc();

    // Normal traffic after reset resumes from address zero
    bus.instr_ready_i = 1'b1;
    send(tbl[8]);
    @(negedge clk);
    chk("resume_word", bus.instr_o, 32'h1021_FFFF);
    chk("resume_addr", bus.addr_o, 32'd0);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have ports: clk_i  in  1  clock, all logic on rising edge.
REQ-002 rst_i  in  1  reset; synchronous and active-high (one clock, synchronous active-high reset).
REQ-003 req_valid_i  in  1  encode request valid; req_ready_o  out  1  request accepted this cycle when both high.
REQ-004 kind_i  in  4  instruction kind: 0 add, 1 sub, 2 and, 3 or, 4 mult, 5 addi, 6 lw, 7 sw, 8 beq, 9 j; 10-15 illegal.
REQ-005 rs_i, rt_i, rd_i  in  5 each  register fields; imm_i  in  16  immediate; target_i  in  26  jump target.
REQ-006 instr_o  out  32  encoded word; instr_valid_o  out  1  word valid; instr_ready_i  in  1  sink accepts when both high.
REQ-007 addr_o  out  32  byte address of the word on instr_o; level_o  out  3  FIFO occupancy 0-4; err_o  out  1  sticky illegal-kind flag.

Function
REQ-008 Encoding SHALL be combinational from request fields, then written into a 4-entry FIFO on request handshake.
REQ-009 R-type (kinds 0-4): op 000000, rs[25:21], rt[20:16], rd[15:11], shamt 0, funct add 100000, sub 100010, and 100100, or 100101, mult 011000.
REQ-010 mult SHALL force rd field to 0 regardless of rd_i.
REQ-011 I-type: op addi 001000, lw 100011, sw 101011, beq 000100; rs[25:21], rt[20:16], imm_i[15:0] unmodified.
REQ-012 j: op 000010, target_i in [25:0]; rs_i/rt_i/rd_i/imm_i ignored.
REQ-013 req_ready_o SHALL be 1 iff level_o < 4; it SHALL NOT depend on instr_ready_i (no same-cycle pass-through when full).
REQ-014 instr_valid_o SHALL be 1 iff level_o > 0; instr_o SHALL show the oldest entry.
REQ-015 Latency: a legal request accepted in cycle N into an empty FIFO SHALL appear on instr_o with instr_valid_o=1 in cycle N+1.
REQ-016 Order SHALL be strictly first-in first-out.
REQ-017 Simultaneous push and pop SHALL leave level_o unchanged and preserve order, including at level 4 is impossible (push blocked) and level 0 (no pop).
REQ-018 instr_o and instr_valid_o SHALL remain stable while instr_valid_o=1 and instr_ready_i=0.
REQ-019 Illegal kind: handshake completes, nothing enqueued, err_o set to 1 on next cycle and held until reset.
REQ-020 addr_o SHALL start at 0 and increment by 4 on each output handshake, wrapping from 0xFFFFFFFC to 0x00000000.
REQ-021 FIFO read/write pointers SHALL be 2-bit and wrap modulo 4.

Reset
REQ-022 While rst_i=1 at a clock edge: level_o=0, instr_valid_o=0, addr_o=0, err_o=0, pointers=0, req_ready_o=1 on following cycle; instr_o=0.
REQ-023 Reset asserted mid-operation SHALL discard all queued words and any request presented that cycle.
REQ-024 Outputs SHALL be defined from the first cycle after reset; no handshake accepted during reset cycle.

Verification
REQ-025 add rs=1 rt=2 rd=3, sink ready -> next cycle instr_o=0x00221820, addr_o=0; after pop addr_o=4.
REQ-026 lw rs=4 rt=5 imm=0x0010 -> 0x8C850010; beq rs=1 rt=1 imm=0xFFFF -> 0x1021FFFF; j target=0x0000040 -> 0x08000040; mult rs=1 rt=2 rd=7 -> 0x00220018.
REQ-027 instr_ready_i=0, five back-to-back requests -> four accepted, level_o=4, req_ready_o=0 on fifth, then four pops return them in order.
REQ-028 kind_i=0xA with valid -> accepted, level_o unchanged, err_o=1 next cycle and stays 1 through later legal traffic.
REQ-029 At level_o=2, push and pop same cycle -> level_o stays 2, popped word is oldest, new word last.
REQ-030 rst_i=1 with level_o=3, addr_o=0x0C, err_o=1 -> next cycle level_o=0, instr_valid_o=0, addr_o=0, err_o=0.
